// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory load/store unit.
// Holds the FSM state encoding, RV32I funct3 size codes and the access legality rule.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // True when funct3 is a legal code for this direction and the address is naturally aligned.
    function automatic logic legal_access(input logic we, input logic [2:0] funct3,
                                          input logic [1:0] addr_lo);
        logic ok;
        ok = 1'b0;
        case (funct3)
            F3_B:    ok = 1'b1;
            F3_BU:   ok = ~we;
            F3_H:    ok = ~addr_lo[0];
            F3_HU:   ok = ~we & ~addr_lo[0];
            F3_W:    ok = (addr_lo == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/dmem_lsu_align.sv
// Combinational byte-lane logic: store byte enables / lane replication and load shift / extend.
// Kept separate so a second memory port reader can reuse the same lane rules.
module dmem_lsu_align #(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr_lo,
    input  logic [XLEN-1:0] wdata,
    input  logic [XLEN-1:0] rdata_raw,
    output logic [3:0]      byteena,
    output logic [XLEN-1:0] wdata_lanes,
    output logic [XLEN-1:0] rdata_ext
);

    logic [XLEN-1:0] shifted;

    always_comb begin
        byteena     = 4'b1111;
        wdata_lanes = wdata;
        case (funct3[1:0])
            2'b00: begin
                byteena     = 4'b0001 << addr_lo;
                wdata_lanes = {4{wdata[7:0]}};
            end
            2'b01: begin
                byteena     = 4'b0011 << addr_lo;
                wdata_lanes = {2{wdata[15:0]}};
            end
            default: begin
                byteena     = 4'b1111;
                wdata_lanes = wdata;
            end
        endcase
    end

    // funct3[2] selects zero extension; the memory has already zeroed lanes outside byteena.
    always_comb begin
        shifted   = rdata_raw >> {addr_lo, 3'b000};
        rdata_ext = shifted;
        case (funct3[1:0])
            2'b00:   rdata_ext = funct3[2] ? {24'h0, shifted[7:0]}
                                           : {{24{shifted[7]}}, shifted[7:0]};
            2'b01:   rdata_ext = funct3[2] ? {16'h0, shifted[15:0]}
                                           : {{16{shifted[15]}}, shifted[15:0]};
            default: rdata_ext = shifted;
        endcase
    end

endmodule

// File: rtl/dmem_lsu.sv
// RV32I load/store unit driving port A of the byte-lane data memory.
// One request at a time: accept, issue one strobe, wait out read latency, pulse a response.
module dmem_lsu
    import dmem_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 12,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [XLEN-1:0]   req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              resp_valid,
    output logic [XLEN-1:0]   resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_address,
    output logic [XLEN-1:0]   mem_data,
    output logic              mem_rden,
    output logic              mem_wren,
    output logic [3:0]        mem_byteena,
    input  logic [XLEN-1:0]   mem_q
);

    localparam logic [1:0] LAT_LAST = 2'(RD_LAT - 1);

    lsu_state_e      state;
    logic            we_reg;
    logic [2:0]      funct3_reg;
    logic [1:0]      addr_lo_reg;
    logic [1:0]      lat_cnt;

    logic [2:0]      align_funct3;
    logic [1:0]      align_addr_lo;
    logic [3:0]      enc_byteena;
    logic [XLEN-1:0] enc_data;
    logic [XLEN-1:0] dec_rdata;
    logic            unused_addr_bits;

    assign unused_addr_bits = ^req_addr[XLEN-1:ADDR_W+2];

    // The encoder sees the incoming request while idle; afterwards the held request drives the decoder.
    assign align_funct3  = (state == IDLE) ? req_funct3    : funct3_reg;
    assign align_addr_lo = (state == IDLE) ? req_addr[1:0] : addr_lo_reg;

    dmem_lsu_align #(.XLEN(XLEN)) u_align (
        .funct3      (align_funct3),
        .addr_lo     (align_addr_lo),
        .wdata       (req_wdata),
        .rdata_raw   (mem_q),
        .byteena     (enc_byteena),
        .wdata_lanes (enc_data),
        .rdata_ext   (dec_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            we_reg      <= 1'b0;
            funct3_reg  <= 3'b000;
            addr_lo_reg <= 2'b00;
            lat_cnt     <= 2'd0;
            req_ready   <= 1'b1;
            resp_valid  <= 1'b0;
            resp_rdata  <= '0;
            resp_err    <= 1'b0;
            mem_address <= '0;
            mem_data    <= '0;
            mem_rden    <= 1'b0;
            mem_wren    <= 1'b0;
            mem_byteena <= 4'b0000;
        end else begin
            mem_rden <= 1'b0;
            mem_wren <= 1'b0;
            case (state)
                IDLE: begin
                    resp_err <= 1'b0;
                    if (req_valid) begin
                        we_reg      <= req_we;
                        funct3_reg  <= req_funct3;
                        addr_lo_reg <= req_addr[1:0];
                        req_ready   <= 1'b0;
                        if (legal_access(req_we, req_funct3, req_addr[1:0])) begin
                            // Address and lanes are frozen here so the memory's lane gating stays valid until capture.
                            mem_address <= req_addr[ADDR_W+1:2];
                            mem_byteena <= enc_byteena;
                            mem_data    <= enc_data;
                            mem_rden    <= ~req_we;
                            mem_wren    <= req_we;
                            state       <= ISSUE;
                        end else begin
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                            state      <= RESP;
                        end
                    end
                end
                ISSUE: begin
                    lat_cnt <= 2'd0;
                    if (we_reg) begin
                        resp_valid <= 1'b1;
                        resp_rdata <= '0;
                        state      <= RESP;
                    end else begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (lat_cnt == LAT_LAST) begin
                        resp_rdata <= dec_rdata;
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end else begin
                        lat_cnt <= lat_cnt + 2'd1;
                    end
                end
                RESP: begin
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    req_ready  <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
